branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Prediction source for the fetch stage, and the receiving end of the branch-resolution interface driven by the execute stage.
- Fetch presents its current PC and gets a same-cycle taken/target prediction.
- Execute returns the resolved outcome (taken, target) for each branch or jump.
- Direct-mapped BTB with per-entry 2-bit saturating counters; the table is cleared by an init FSM after reset.

Parameters:
INDEX_BITS, 6, log2 of entry count (64 entries); index = pc[INDEX_BITS+1:2]
TAG_BITS, 8, tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
ALLOC_CTR, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset (0 = reset)
pc_f  input  32  fetch-stage PC for lookup
predict_taken_f  output  1  predicted taken for pc_f (combinational)
predict_target_f  output  32  predicted target for pc_f (combinational; 0 when not taken)
upd_valid  input  1  resolution valid this cycle (branch or jump in execute)
upd_pc  input  32  PC of the resolved instruction
upd_taken  input  1  actual outcome
upd_target  input  32  actual target
upd_pred_taken  input  1  prediction carried down the pipe for this instruction
init_busy  output  1  high while the table is being cleared

Behaviour:
- Storage per entry: valid, tag[TAG_BITS], target[32], ctr[2]. Register array with asynchronous read and write at the clock edge.
- FSM states: INIT and RUN.
  - rst=0 at a clock edge: state goes to INIT and clr_idx goes to 0. This applies at any time, including mid-RUN or mid-INIT, which restarts the clear.
  - INIT: each cycle, entry[clr_idx] gets valid=0 and ctr=2'b01; clr_idx increments.
  - INIT exits to RUN on the cycle clr_idx == 2^INDEX_BITS-1 is written. Clear takes exactly 2^INDEX_BITS cycles.
  - In INIT: init_busy=1, predict_taken_f=0, predict_target_f=0, and upd_valid is ignored.
- Reset values: init_busy=1 from the first post-reset cycle. predict_taken_f=0 and predict_target_f=0 throughout INIT.
- Lookup (RUN):
  - hit = valid && tag match for pc_f's index.
  - predict_taken_f = hit && ctr[1].
  - predict_target_f = target when predict_taken_f, else 0.
- Update (RUN, upd_valid=1), applied at the clock edge:
  - Hit on upd_pc, taken: ctr saturates upward (max 2'b11); target is overwritten with upd_target.
  - Hit, not taken: ctr saturates downward (min 2'b00); target is unchanged; valid stays 1.
  - Miss, taken: allocate. valid=1, tag, target=upd_target, ctr=ALLOC_CTR. Replaces any resident entry at that index.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The new value is visible the next cycle.
- upd_pc bits [1:0] are ignored. Index and tag use only the bit slices above.
- upd_pred_taken is used only by the optional feature. With the feature compiled out it is unconnected and has no effect.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, adds outputs perf_branches[32] and perf_mispredicts[32]. Both reset to 0 on rst=0 and hold during INIT.
- In RUN, each cycle with upd_valid=1:
  - perf_branches increments.
  - perf_mispredicts increments when upd_pred_taken != upd_taken.
  - Both wrap from 0xFFFFFFFF to 0.
- When not defined, these ports and counters do not exist. Predictor behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release. init_busy=1 for exactly 64 cycles, then 0. predict_taken_f=0 for every pc_f throughout.
- Allocation after init:
  - Apply upd_valid=1, upd_pc=0x00000040, upd_taken=1, upd_target=0x00000100.
  - Next cycle, pc_f=0x40 gives predict_taken_f=1, predict_target_f=0x100.
  - pc_f=0x4040 (same index, different tag) gives predict_taken_f=0.
- Saturation and hysteresis:
  - Start from the allocated entry (ctr=10). Apply 2 taken updates, so ctr=11.
  - After 1 not-taken update, still predicts taken.
  - After a 2nd not-taken update, predict_taken_f=0.
  - After 3 more not-taken updates, ctr stays 00 and the entry stays valid.
- Same-cycle collision: pc_f=0x80 with simultaneous allocating update to 0x80. predict_taken_f=0 that cycle, 1 the following cycle.
- Reset mid-operation: after 10 allocations, pulse rst=0 for 1 cycle during RUN. init_busy rises, and after 64 cycles all 10 PCs predict not-taken.
- With BP_PERF_CNT_EN:
  - 5 updates with upd_pred_taken!=upd_taken on 2 of them give perf_branches=5, perf_mispredicts=2.
  - Preload perf_branches=0xFFFFFFFF via force; one update wraps it to 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// branch_target_predictor
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Fetch gets a same-cycle taken/target prediction for pc_f, and execute feeds
// resolved outcomes back through the upd_* inputs. After every reset an init
// FSM walks the whole table and clears it before predictions are enabled.
// Optional build macro: BP_PERF_CNT_EN adds branch and mispredict counters.
module branch_target_predictor #(
   parameter int         INDEX_BITS = 6,
   parameter int         TAG_BITS   = 8,
   parameter logic [1:0] ALLOC_CTR  = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        predict_taken_f,
   output logic [31:0] predict_target_f,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   output logic        init_busy
`ifdef BP_PERF_CNT_EN
   ,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
`endif
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_LO  = INDEX_BITS + 2;
   localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [INDEX_BITS-1:0] clr_idx;
   logic [INDEX_BITS-1:0] clr_idx_next;

   logic                  valid_mem  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
   logic [31:0]           target_mem [ENTRIES];
   logic [1:0]            ctr_mem    [ENTRIES];

   logic [INDEX_BITS-1:0] idx_f;
   logic [TAG_BITS-1:0]   tag_f;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  upd_hit;

   logic                  wr_en;
   logic [INDEX_BITS-1:0] wr_idx;
   logic                  wr_valid;
   logic [TAG_BITS-1:0]   wr_tag;
   logic [31:0]           wr_target;
   logic [1:0]            wr_ctr;

   // PC bits outside the index/tag slices never affect the table
   logic unused_bits;
`ifdef BP_PERF_CNT_EN
   assign unused_bits = ^{pc_f[1:0], pc_f[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1]};
`else
   assign unused_bits = ^{pc_f[1:0], pc_f[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1],
                          upd_pred_taken};
`endif

   assign idx_f   = pc_f[TAG_LO-1:2];
   assign tag_f   = pc_f[TAG_HI:TAG_LO];
   assign upd_idx = upd_pc[TAG_LO-1:2];
   assign upd_tag = upd_pc[TAG_HI:TAG_LO];
   assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);

   // State register; a low rst restarts the table clear from entry 0 at any time
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= INIT;
         clr_idx <= '0;
      end else begin
         state   <= state_next;
         clr_idx <= clr_idx_next;
      end
   end

   // Next state: walk every entry once during INIT, then stay in RUN
   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      init_busy    = 1'b0;
      unique case (state)
         INIT: begin
            init_busy    = 1'b1;
            clr_idx_next = clr_idx + 1'b1;
            if (clr_idx == {INDEX_BITS{1'b1}}) begin
               state_next = RUN;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   // Lookup reads the table as it stands before this cycle's update lands
   always_comb begin
      predict_taken_f  = 1'b0;
      predict_target_f = '0;
      if ((state == RUN) && valid_mem[idx_f] && (tag_mem[idx_f] == tag_f)
          && ctr_mem[idx_f][1]) begin
         predict_taken_f  = 1'b1;
         predict_target_f = target_mem[idx_f];
      end
   end

   // Choose the single table write for this cycle: clear during INIT, else train
   always_comb begin
      wr_en     = 1'b0;
      wr_idx    = upd_idx;
      wr_valid  = 1'b1;
      wr_tag    = upd_tag;
      wr_target = target_mem[upd_idx];
      wr_ctr    = ctr_mem[upd_idx];
      if (state == INIT) begin
         wr_en     = 1'b1;
         wr_idx    = clr_idx;
         wr_valid  = 1'b0;
         wr_tag    = '0;
         wr_target = '0;
         wr_ctr    = 2'b01;
      end else if (upd_valid) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (upd_taken) begin
               wr_target = upd_target;
               wr_ctr    = (ctr_mem[upd_idx] == 2'b11) ? 2'b11 : ctr_mem[upd_idx] + 2'd1;
            end else begin
               wr_ctr    = (ctr_mem[upd_idx] == 2'b00) ? 2'b00 : ctr_mem[upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            wr_en     = 1'b1;
            wr_target = upd_target;
            wr_ctr    = ALLOC_CTR;
         end
      end
   end

   // Table write port; reset only restarts the clear, it never writes an entry
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         valid_mem[wr_idx]  <= wr_valid;
         tag_mem[wr_idx]    <= wr_tag;
         target_mem[wr_idx] <= wr_target;
         ctr_mem[wr_idx]    <= wr_ctr;
      end
   end

`ifdef BP_PERF_CNT_EN
   // Count resolved branches and mispredictions while running, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if ((state == RUN) && upd_valid) begin
         perf_branches <= perf_branches + 32'd1;
         if (upd_pred_taken != upd_taken) begin
            perf_mispredicts <= perf_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
// Directed bench for branch_target_predictor: init clear length, allocation,
// counter hysteresis and saturation, same-cycle collision and mid-run reset.
// Build with BP_PERF_CNT_EN defined to also exercise the performance counters.
module tb_branch_target_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] pc_f;
   logic        predict_taken_f;
   logic [31:0] predict_target_f;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic        init_busy;
`ifdef BP_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
`endif

   int checks;
   int errors;
   int busy_cycles;

   branch_target_predictor dut (
      .clk              (clk),
      .rst              (rst),
      .pc_f             (pc_f),
      .predict_taken_f  (predict_taken_f),
      .predict_target_f (predict_target_f),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .init_busy        (init_busy)
`ifdef BP_PERF_CNT_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything below stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // One resolved branch, applied at the next rising edge
   task automatic applyStimulus(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input logic pred);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_taken      = taken;
      upd_target     = target;
      upd_pred_taken = pred;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   // Present a fetch PC and compare the combinational prediction
   task automatic probe(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_target);
      pc_f = pc;
      #1;
      checkOutput({tag, "_taken"}, {31'b0, predict_taken_f}, {31'b0, exp_taken});
      checkOutput({tag, "_target"}, predict_target_f, exp_target);
   endtask

   // Count busy cycles of a clear; also tries an update mid-clear that must be ignored
   task automatic measureInit(output int cycles);
      cycles = 0;
      for (int i = 0; i < 200; i++) begin
         pc_f = 32'h1000 + 32'(i * 4);
         if (i == 40) begin
            upd_valid      = 1'b1;
            upd_pc         = 32'h0000_1000;
            upd_taken      = 1'b1;
            upd_target     = 32'h0000_DEAD;
            upd_pred_taken = 1'b0;
         end else begin
            upd_valid = 1'b0;
         end
         @(negedge clk);
         if (!init_busy) begin
            break;
         end
         cycles++;
         checkOutput("init_pred_taken", {31'b0, predict_taken_f}, 32'd0);
         checkOutput("init_pred_target", predict_target_f, 32'd0);
         @(posedge clk);
         #1;
      end
      upd_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b0;
      pc_f           = '0;
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_pred_taken = 1'b0;

      $display("[TB] reset and initial clear");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("reset_busy", {31'b0, init_busy}, 32'd1);
      measureInit(busy_cycles);
      checkOutput("init_length", 32'(busy_cycles), 32'd64);
      checkOutput("run_busy", {31'b0, init_busy}, 32'd0);

      $display("[TB] allocation");
      probe("pre_alloc", 32'h0000_0040, 1'b0, 32'h0);
      applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
      probe("alloc_hit", 32'h0000_0040, 1'b1, 32'h0000_0100);
      probe("alloc_alias", 32'h0000_4040, 1'b0, 32'h0);

      $display("[TB] saturation and hysteresis");
      applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b1);
      applyStimulus(32'h0000_0043, 1'b1, 32'h0000_0100, 1'b1);
      applyStimulus(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b1);
      probe("one_nt", 32'h0000_0040, 1'b1, 32'h0000_0100);
      applyStimulus(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b1);
      probe("two_nt", 32'h0000_0040, 1'b0, 32'h0);
      repeat (3) applyStimulus(32'h0000_0040, 1'b0, 32'h0000_0999, 1'b0);
      probe("five_nt", 32'h0000_0040, 1'b0, 32'h0);
      applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0);
      probe("floor_plus1", 32'h0000_0040, 1'b0, 32'h0);
      applyStimulus(32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0);
      probe("floor_plus2", 32'h0000_0040, 1'b1, 32'h0000_0200);

      $display("[TB] miss handling");
      applyStimulus(32'h0000_4040, 1'b0, 32'h0000_0300, 1'b0);
      probe("miss_nt_alias", 32'h0000_4040, 1'b0, 32'h0);
      probe("miss_nt_keep", 32'h0000_0040, 1'b1, 32'h0000_0200);
      applyStimulus(32'h0000_4040, 1'b1, 32'h0000_0300, 1'b0);
      probe("replace_new", 32'h0000_4040, 1'b1, 32'h0000_0300);
      probe("replace_old", 32'h0000_0040, 1'b0, 32'h0);

      $display("[TB] same-cycle collision");
      pc_f           = 32'h0000_0080;
      upd_valid      = 1'b1;
      upd_pc         = 32'h0000_0080;
      upd_taken      = 1'b1;
      upd_target     = 32'h0000_0180;
      upd_pred_taken = 1'b0;
      #1;
      checkOutput("collide_same", {31'b0, predict_taken_f}, 32'd0);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      probe("collide_next", 32'h0000_0080, 1'b1, 32'h0000_0180);

      $display("[TB] reset during run");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(32'h0000_1000 + 32'(k * 4), 1'b1, 32'h0000_2000 + 32'(k * 16), 1'b0);
      end
      probe("ten_first", 32'h0000_1000, 1'b1, 32'h0000_2000);
      probe("ten_last", 32'h0000_1024, 1'b1, 32'h0000_2090);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("pulse_busy", {31'b0, init_busy}, 32'd1);
      measureInit(busy_cycles);
      checkOutput("reinit_length", 32'(busy_cycles), 32'd64);
      for (int k = 0; k < 10; k++) begin
         probe($sformatf("cleared_%0d", k), 32'h0000_1000 + 32'(k * 4), 1'b0, 32'h0);
      end

`ifdef BP_PERF_CNT_EN
      $display("[TB] performance counters");
      checkOutput("perf_br_reset", perf_branches, 32'd0);
      checkOutput("perf_mp_reset", perf_mispredicts, 32'd0);
      applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b0);
      applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1);
      applyStimulus(32'h0000_0200, 1'b0, 32'h0000_0400, 1'b1);
      applyStimulus(32'h0000_0204, 1'b0, 32'h0000_0400, 1'b0);
      applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1);
      checkOutput("perf_br_five", perf_branches, 32'd5);
      checkOutput("perf_mp_two", perf_mispredicts, 32'd2);
      force dut.perf_branches = 32'hFFFF_FFFF;
      #1;
      release dut.perf_branches;
      applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1);
      checkOutput("perf_br_wrap", perf_branches, 32'd0);
      checkOutput("perf_mp_hold", perf_mispredicts, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
